// File: rtl/instruction_fetch_queue.sv
// Sequential instruction fetch with a DEPTH-entry queue toward the core and redirect/flush support.
// Optional IFQ_BYPASS_EN: forwards an ack word straight to the core when the queue is empty.
module instruction_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t      state, state_next;
    logic [31:0] fetch_pc, req_addr;
    logic [31:0] mem_instr [DEPTH];
    logic [31:0] mem_pc    [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
    logic [AW:0] count, count_after_pop, count_next;
    logic        out_valid;
    logic [31:0] out_instr, out_pc, head_instr, head_pc;
    logic        issue, landed, bypass, push, pop;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (issue) state_next = WAIT;
            WAIT:    if (imem_ack) state_next = IDLE;
                     else if (redirect) state_next = DROP;
            DROP:    if (imem_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state != IDLE);
        imem_addr = req_addr;
        issue     = (state == IDLE) && !redirect && (count < FULL);
        landed    = (state == WAIT) && imem_ack && !redirect;
`ifdef IFQ_BYPASS_EN
        bypass    = landed && (count == '0) && instr_ready;
`else
        bypass    = 1'b0;
`endif
        push        = landed && !bypass;
        pop         = out_valid && instr_ready;
        instr_valid = out_valid;
        instruction = out_instr;
        instr_pc    = out_pc;
        if (bypass) begin
            instr_valid = 1'b1;
            instruction = imem_rdata;
            instr_pc    = req_addr;
        end
    end

    // Next head: the word being pushed if the queue drains to empty this cycle, else the entry after pop.
    always_comb begin
        rd_next         = rd_ptr + AW'(pop);
        count_after_pop = count - (AW + 1)'(pop);
        count_next      = count_after_pop + (AW + 1)'(push);
        head_instr      = mem_instr[rd_next];
        head_pc         = mem_pc[rd_next];
        if ((count_after_pop == '0) && push) begin
            head_instr = imem_rdata;
            head_pc    = req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_instr[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]    <= req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            req_addr  <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else begin
            if (issue) req_addr <= fetch_pc;
            if (redirect)    fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (landed) fetch_pc <= fetch_pc + 32'd4;
            if (redirect) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
                out_valid <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                rd_ptr    <= rd_next;
                count     <= count_next;
                out_valid <= (count_next != '0);
                if (count_next != '0) begin
                    out_instr <= head_instr;
                    out_pc    <= head_pc;
                end
            end
        end
    end

endmodule
